// File: rtl/riscv_test_ctrl.sv
// Run controller: sequences core reset, counts RUN cycles and retired instructions,
// and ends the run on a tohost write (pass/fail) or on the cycle budget (timeout).
module riscv_test_ctrl #(
  parameter int unsigned       RST_CYCLES     = 2,
  parameter int unsigned       TIMEOUT_CYCLES = 5000,
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       CNT_W          = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(32'h0000_1000)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              core_rst,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              instret,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [DATA_W-2:0] fail_code,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instret_count
);

  localparam int unsigned HOLD_W = $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_HOLD = 3'd0,
    ST_RUN  = 3'd1,
    ST_PASS = 3'd2,
    ST_FAIL = 3'd3,
    ST_TOUT = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                core_rst_q, core_rst_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic                timeout_q, timeout_d;
  logic [DATA_W-2:0]   fail_code_q, fail_code_d;
  logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0]    instret_count_q, instret_count_d;

  logic                tohost_hit_c;

  // A tohost write only reports when bit 0 is set; other writes are plain stores.
  assign tohost_hit_c = mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_HOLD;
      hold_cnt_q      <= '0;
      core_rst_q      <= 1'b1;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      fail_q          <= 1'b0;
      timeout_q       <= 1'b0;
      fail_code_q     <= '0;
      cycle_count_q   <= '0;
      instret_count_q <= '0;
    end else begin
      state_q         <= state_d;
      hold_cnt_q      <= hold_cnt_d;
      core_rst_q      <= core_rst_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      fail_q          <= fail_d;
      timeout_q       <= timeout_d;
      fail_code_q     <= fail_code_d;
      cycle_count_q   <= cycle_count_d;
      instret_count_q <= instret_count_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d         = state_q;
    hold_cnt_d      = hold_cnt_q;
    core_rst_d      = core_rst_q;
    done_d          = done_q;
    pass_d          = pass_q;
    fail_d          = fail_q;
    timeout_d       = timeout_q;
    fail_code_d     = fail_code_q;
    cycle_count_d   = cycle_count_q;
    instret_count_d = instret_count_q;

    case (state_q)
      ST_HOLD: begin
        core_rst_d = 1'b1;
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        // core_rst drops on the same edge the counter reaches RST_CYCLES.
        if (hold_cnt_q == HOLD_W'(RST_CYCLES - 1)) begin
          state_d    = ST_RUN;
          core_rst_d = 1'b0;
        end
      end

      ST_RUN: begin
        if (cycle_count_q != '1) begin
          cycle_count_d = cycle_count_q + CNT_W'(1);
        end
        if (instret && (instret_count_q != '1)) begin
          instret_count_d = instret_count_q + CNT_W'(1);
        end

        if (tohost_hit_c) begin
          done_d     = 1'b1;
          core_rst_d = 1'b1;
          if (mem_wdata == DATA_W'(1)) begin
            state_d = ST_PASS;
            pass_d  = 1'b1;
          end else begin
            state_d     = ST_FAIL;
            fail_d      = 1'b1;
            fail_code_d = mem_wdata[DATA_W-1:1];
          end
        end else if (cycle_count_d == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d    = ST_TOUT;
          done_d     = 1'b1;
          timeout_d  = 1'b1;
          core_rst_d = 1'b1;
        end
      end

      ST_PASS, ST_FAIL, ST_TOUT: begin
        core_rst_d = 1'b1;
        done_d     = 1'b1;
      end

      default: begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
        core_rst_d = 1'b1;
      end
    endcase
  end

  assign core_rst      = core_rst_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign timeout       = timeout_q;
  assign fail_code     = fail_code_q;
  assign cycle_count   = cycle_count_q;
  assign instret_count = instret_count_q;

endmodule

// File: tb/tb_riscv_test_ctrl.sv
// Directed bench for riscv_test_ctrl: default-budget instance plus a 50-cycle-budget instance.
module tb_riscv_test_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        instret;

  logic        core_rst, done, pass, fail, timeout;
  logic [30:0] fail_code;
  logic [31:0] cycle_count, instret_count;

  logic        t_core_rst, t_done, t_pass, t_fail, t_timeout;
  logic [30:0] t_fail_code;
  logic [31:0] t_cycle_count, t_instret_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  riscv_test_ctrl dut (
    .clk(clk), .rst(rst), .core_rst(core_rst),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .instret(instret),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout), .fail_code(fail_code),
    .cycle_count(cycle_count), .instret_count(instret_count)
  );

  riscv_test_ctrl #(.TIMEOUT_CYCLES(50)) dut_t (
    .clk(clk), .rst(rst), .core_rst(t_core_rst),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .instret(instret),
    .done(t_done), .pass(t_pass), .fail(t_fail), .timeout(t_timeout), .fail_code(t_fail_code),
    .cycle_count(t_cycle_count), .instret_count(t_instret_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic no_write();
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d);
    mem_we    = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
  endtask

  // Reset for two cycles, then two HOLD cycles; returns at the start of RUN cycle 1.
  task automatic release_rst();
    rst = 1'b1;
    no_write();
    instret = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    no_write();
    instret = 1'b0;
    idle(2);
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst got=%0b exp=1", core_rst); end
    checks++; if ({done, pass, fail, timeout} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {done, pass, fail, timeout}); end
    checks++; if (cycle_count !== 32'd0 || instret_count !== 32'd0 || fail_code !== 31'd0) begin
      errors++; $display("FAIL reset_counters got=%0d/%0d/%0h exp=0/0/0", cycle_count, instret_count, fail_code); end
    // One HOLD cycle, then rst again: hold counter must restart.
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    write(32'h1000, 32'h1);
    instret = 1'b1;
    step();
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL hold_after_E0 got=%0b exp=1", core_rst); end
    step();
    no_write();
    instret = 1'b0;
    checks++; if (core_rst !== 1'b0) begin errors++; $display("FAIL hold_release got=%0b exp=0", core_rst); end
    checks++; if (cycle_count !== 32'd0 || instret_count !== 32'd0 || done !== 1'b0) begin
      errors++; $display("FAIL run_start got=cyc%0d ins%0d done%0b exp=0 0 0", cycle_count, instret_count, done); end
    step();
    checks++; if (cycle_count !== 32'd1) begin errors++; $display("FAIL run_first_count got=%0d exp=1", cycle_count); end
  endtask

  task automatic test_pass();
    release_rst();
    for (int c = 1; c <= 99; c++) begin
      instret = (c <= 37);
      step();
    end
    instret = 1'b0;
    write(32'h1000, 32'h1);
    step();
    no_write();
    checks++; if ({done, pass, fail, timeout} !== 4'b1100) begin errors++; $display("FAIL pass_flags got=%b exp=1100", {done, pass, fail, timeout}); end
    checks++; if (cycle_count !== 32'd100) begin errors++; $display("FAIL pass_cycles got=%0d exp=100", cycle_count); end
    checks++; if (instret_count !== 32'd37) begin errors++; $display("FAIL pass_instret got=%0d exp=37", instret_count); end
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL pass_core_rst got=%0b exp=1", core_rst); end
    instret = 1'b1;
    write(32'h1000, 32'h2B);
    idle(10);
    instret = 1'b0;
    no_write();
    checks++; if (cycle_count !== 32'd100 || instret_count !== 32'd37) begin
      errors++; $display("FAIL pass_frozen got=%0d/%0d exp=100/37", cycle_count, instret_count); end
    checks++; if ({done, pass, fail, timeout} !== 4'b1100) begin errors++; $display("FAIL pass_sticky got=%b exp=1100", {done, pass, fail, timeout}); end
  endtask

  task automatic test_ignored_and_fail();
    release_rst();
    write(32'h1004, 32'h1);
    step();
    write(32'h1000, 32'h4);
    step();
    no_write();
    checks++; if ({done, pass, fail, timeout} !== 4'b0000 || core_rst !== 1'b0) begin
      errors++; $display("FAIL ignored_writes got=%b core_rst=%0b exp=0000 0", {done, pass, fail, timeout}, core_rst); end
    checks++; if (cycle_count !== 32'd2) begin errors++; $display("FAIL ignored_cycles got=%0d exp=2", cycle_count); end
    write(32'h1000, 32'h2B);
    step();
    no_write();
    checks++; if ({done, pass, fail, timeout} !== 4'b1010) begin errors++; $display("FAIL fail_flags got=%b exp=1010", {done, pass, fail, timeout}); end
    checks++; if (fail_code !== 31'h15) begin errors++; $display("FAIL fail_code got=%0h exp=15", fail_code); end
    checks++; if (cycle_count !== 32'd3) begin errors++; $display("FAIL fail_cycles got=%0d exp=3", cycle_count); end
  endtask

  task automatic test_timeout();
    release_rst();
    idle(49);
    checks++; if (t_timeout !== 1'b0 || t_cycle_count !== 32'd49) begin
      errors++; $display("FAIL tout_early got=%0b/%0d exp=0/49", t_timeout, t_cycle_count); end
    step();
    checks++; if ({t_done, t_pass, t_fail, t_timeout} !== 4'b1001) begin
      errors++; $display("FAIL tout_flags got=%b exp=1001", {t_done, t_pass, t_fail, t_timeout}); end
    checks++; if (t_cycle_count !== 32'd50 || t_core_rst !== 1'b1) begin
      errors++; $display("FAIL tout_state got=%0d/%0b exp=50/1", t_cycle_count, t_core_rst); end
    idle(3);
    checks++; if (t_cycle_count !== 32'd50) begin errors++; $display("FAIL tout_frozen got=%0d exp=50", t_cycle_count); end
  endtask

  task automatic test_collision();
    release_rst();
    idle(49);
    write(32'h1000, 32'h1);
    step();
    no_write();
    checks++; if (t_pass !== 1'b1 || t_timeout !== 1'b0) begin
      errors++; $display("FAIL collision got=pass%0b tout%0b exp=pass1 tout0", t_pass, t_timeout); end
    checks++; if (t_cycle_count !== 32'd50) begin errors++; $display("FAIL collision_cycles got=%0d exp=50", t_cycle_count); end
  endtask

  task automatic test_midrun_reset();
    release_rst();
    instret = 1'b1;
    idle(29);
    instret = 1'b0;
    rst = 1'b1;
    step();
    checks++; if (cycle_count !== 32'd0 || instret_count !== 32'd0) begin
      errors++; $display("FAIL midrst_counters got=%0d/%0d exp=0/0", cycle_count, instret_count); end
    checks++; if (core_rst !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL midrst_state got=core_rst%0b done%0b exp=1 0", core_rst, done); end
    rst = 1'b0;
    step();
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL midrst_hold got=%0b exp=1", core_rst); end
    step();
    checks++; if (core_rst !== 1'b0) begin errors++; $display("FAIL midrst_release got=%0b exp=0", core_rst); end
    for (int c = 1; c <= 4; c++) begin
      instret = (c == 2 || c == 3);
      step();
    end
    instret = 1'b1;
    write(32'h1000, 32'h1);
    step();
    instret = 1'b0;
    no_write();
    checks++; if ({done, pass, fail, timeout} !== 4'b1100) begin errors++; $display("FAIL midrst_pass got=%b exp=1100", {done, pass, fail, timeout}); end
    checks++; if (cycle_count !== 32'd5 || instret_count !== 32'd3) begin
      errors++; $display("FAIL midrst_counts got=%0d/%0d exp=5/3", cycle_count, instret_count); end
  endtask

  initial begin
    rst = 1'b1;
    instret = 1'b0;
    no_write();
    test_reset();
    test_pass();
    test_ignored_and_fail();
    test_timeout();
    test_collision();
    test_midrun_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
